// File: rtl/bnn_pkg.sv
// Shared types, default widths and the saturating-add helper for the BNN accumulator back end.
package bnn_pkg;

   localparam int BNN_N_CH     = 8;
   localparam int BNN_PSUM_W   = 7;
   localparam int BNN_BIAS_W   = 8;
   localparam int BNN_ACC_W    = 12;
   localparam int BNN_IN_LANES = 4;
   localparam int BNN_POOL_MAX = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_OUT   = 2'd2
   } bnn_state_e;

   localparam logic [1:0] S_IDLE  = ST_IDLE;
   localparam logic [1:0] S_ACCUM = ST_ACCUM;
   localparam logic [1:0] S_OUT   = ST_OUT;

   // Adds two sign-extended operands and clamps to a w-bit signed range; bit 32 flags a clamp.
   function automatic logic [32:0] sat_add(input logic signed [31:0] a,
                                           input logic signed [31:0] b,
                                           input int                 w);
      logic signed [32:0] sum;
      logic signed [32:0] hi;
      logic signed [32:0] lo;
      logic        [32:0] r;
      sum = $signed({a[31], a}) + $signed({b[31], b});
      hi  = (33'sd1 <<< (w - 1)) - 33'sd1;
      lo  = -(33'sd1 <<< (w - 1));
      if (sum > hi) begin
         r = {1'b1, hi[31:0]};
      end else if (sum < lo) begin
         r = {1'b1, lo[31:0]};
      end else begin
         r = {1'b0, sum[31:0]};
      end
      return r;
   endfunction

endpackage

// File: rtl/bnn_accum_core_if.sv
// Bias load, psum stream, result stream and status bundle of the BNN accumulator core.
interface bnn_accum_core_if
   import bnn_pkg::*;
#(
   parameter int N_CH     = BNN_N_CH,
   parameter int PSUM_W   = BNN_PSUM_W,
   parameter int BIAS_W   = BNN_BIAS_W,
   parameter int IN_LANES = BNN_IN_LANES,
   parameter int POOL_MAX = BNN_POOL_MAX
);
   localparam int CNT_W = $clog2(POOL_MAX) + 1;

   logic                       bias_valid;
   logic                       bias_ready;
   logic [IN_LANES*BIAS_W-1:0] bias_data;
   logic                       start;
   logic [CNT_W-1:0]           cfg_pool_n;
   logic                       abort;
   logic                       psum_valid;
   logic                       psum_ready;
   logic [N_CH*PSUM_W-1:0]     psum_in;
   logic                       psum_last;
   logic                       out_valid;
   logic                       out_ready;
   logic [N_CH-1:0]            out_bins;
   logic                       busy;
   logic                       sat;

   modport master (
      output bias_valid, bias_data, start, cfg_pool_n, abort,
             psum_valid, psum_in, psum_last, out_ready,
      input  bias_ready, psum_ready, out_valid, out_bins, busy, sat
   );

   modport slave (
      input  bias_valid, bias_data, start, cfg_pool_n, abort,
             psum_valid, psum_in, psum_last, out_ready,
      output bias_ready, psum_ready, out_valid, out_bins, busy, sat
   );

endinterface

// File: rtl/bnn_sat_acc.sv
// One accumulator lane: holds a signed sum, adds a psum with saturation and exposes sign bit and clamp.
module bnn_sat_acc
   import bnn_pkg::*;
#(
   parameter int ACC_W  = BNN_ACC_W,
   parameter int PSUM_W = BNN_PSUM_W,
   parameter int BIAS_W = BNN_BIAS_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              add,
   input  logic [BIAS_W-1:0] bias,
   input  logic [PSUM_W-1:0] psum,
   output logic              bin,
   output logic              clamp
);

   logic [ACC_W-1:0] acc_q;
   logic [ACC_W-1:0] acc_d;
   logic [ACC_W-1:0] nxt_s;
   logic [32:0]      sum_s;
   logic             sum_unused_s;

   // Candidate sum; a zero result binarises to 1 since only the sign bit is inverted.
   always_comb begin
      sum_s = sat_add({{(32-ACC_W){acc_q[ACC_W-1]}}, acc_q},
                      {{(32-PSUM_W){psum[PSUM_W-1]}}, psum}, ACC_W);
      nxt_s = sum_s[ACC_W-1:0];
      clamp = sum_s[32];
      bin   = ~nxt_s[ACC_W-1];
   end

   assign sum_unused_s = ^sum_s[31:ACC_W];

   // Reloading the bias wins over adding, so a window's last beat restarts the lane.
   always_comb begin
      if (load) begin
         acc_d = {{(ACC_W-BIAS_W){bias[BIAS_W-1]}}, bias};
      end else if (add) begin
         acc_d = nxt_s;
      end else begin
         acc_d = acc_q;
      end
   end

   // Accumulator register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= {ACC_W{1'b0}};
      end else begin
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/bnn_accum_core.sv
// BNN layer back end: bias preload, per-channel saturating accumulation, sign binarisation and OR-pooling.
module bnn_accum_core
   import bnn_pkg::*;
#(
   parameter int N_CH     = BNN_N_CH,
   parameter int PSUM_W   = BNN_PSUM_W,
   parameter int BIAS_W   = BNN_BIAS_W,
   parameter int ACC_W    = BNN_ACC_W,
   parameter int IN_LANES = BNN_IN_LANES,
   parameter int POOL_MAX = BNN_POOL_MAX
) (
   input logic               clk,
   input logic               rst_n,
   bnn_accum_core_if.slave   bus
);

   localparam int CNT_W    = $clog2(POOL_MAX) + 1;
   localparam int BIAS_TOT = N_CH * BIAS_W;
   localparam int BEAT_W   = IN_LANES * BIAS_W;

   logic [1:0]          state_q;
   logic [1:0]          state_d;
   logic [BIAS_TOT-1:0] bias_q;
   logic [BIAS_TOT-1:0] bias_d;
   logic [CNT_W-1:0]    pool_n_q;
   logic [CNT_W-1:0]    pool_n_d;
   logic [CNT_W-1:0]    pool_cnt_q;
   logic [CNT_W-1:0]    pool_cnt_d;
   logic [CNT_W-1:0]    pool_n_cfg_s;
   logic [N_CH-1:0]     pool_reg_q;
   logic [N_CH-1:0]     pool_reg_d;
   logic [N_CH-1:0]     out_bins_q;
   logic [N_CH-1:0]     out_bins_d;
   logic [N_CH-1:0]     bin_s;
   logic [N_CH-1:0]     clamp_s;
   logic                sat_q;
   logic                sat_d;
   logic                lane_load_s;
   logic                lane_add_s;

   // Window count: zero means one window, anything beyond POOL_MAX is clamped.
   always_comb begin
      if (bus.cfg_pool_n == {CNT_W{1'b0}}) begin
         pool_n_cfg_s = CNT_W'(1);
      end else if (bus.cfg_pool_n > CNT_W'(POOL_MAX)) begin
         pool_n_cfg_s = CNT_W'(POOL_MAX);
      end else begin
         pool_n_cfg_s = bus.cfg_pool_n;
      end
   end

   // Control FSM, bias shifter and pooling; abort outranks every handshake outside IDLE.
   always_comb begin
      state_d     = state_q;
      bias_d      = bias_q;
      pool_n_d    = pool_n_q;
      pool_cnt_d  = pool_cnt_q;
      pool_reg_d  = pool_reg_q;
      out_bins_d  = out_bins_q;
      sat_d       = sat_q;
      lane_load_s = 1'b0;
      lane_add_s  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.bias_valid) begin
               bias_d = (bias_q << BEAT_W) | BIAS_TOT'(bus.bias_data);
            end else begin
               bias_d = bias_q;
            end
            if (bus.start) begin
               pool_n_d    = pool_n_cfg_s;
               pool_cnt_d  = {CNT_W{1'b0}};
               pool_reg_d  = {N_CH{1'b0}};
               sat_d       = 1'b0;
               lane_load_s = 1'b1;
               state_d     = S_ACCUM;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ACCUM: begin
            if (bus.abort) begin
               state_d = S_IDLE;
            end else if (bus.psum_valid) begin
               lane_add_s = 1'b1;
               sat_d      = sat_q | (|clamp_s);
               if (bus.psum_last) begin
                  lane_load_s = 1'b1;
                  pool_reg_d  = pool_reg_q | bin_s;
                  if (pool_cnt_q + CNT_W'(1) == pool_n_q) begin
                     out_bins_d = pool_reg_q | bin_s;
                     state_d    = S_OUT;
                  end else begin
                     pool_cnt_d = pool_cnt_q + CNT_W'(1);
                  end
               end else begin
                  lane_load_s = 1'b0;
               end
            end else begin
               state_d = S_ACCUM;
            end
         end
         S_OUT: begin
            if (bus.abort || bus.out_ready) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_OUT;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Control and pooling state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         bias_q     <= {BIAS_TOT{1'b0}};
         pool_n_q   <= CNT_W'(1);
         pool_cnt_q <= {CNT_W{1'b0}};
         pool_reg_q <= {N_CH{1'b0}};
         out_bins_q <= {N_CH{1'b0}};
         sat_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         bias_q     <= bias_d;
         pool_n_q   <= pool_n_d;
         pool_cnt_q <= pool_cnt_d;
         pool_reg_q <= pool_reg_d;
         out_bins_q <= out_bins_d;
         sat_q      <= sat_d;
      end
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_lane
      bnn_sat_acc #(
         .ACC_W  (ACC_W),
         .PSUM_W (PSUM_W),
         .BIAS_W (BIAS_W)
      ) u_lane (
         .clk   (clk),
         .rst_n (rst_n),
         .load  (lane_load_s),
         .add   (lane_add_s),
         .bias  (bias_q[i*BIAS_W +: BIAS_W]),
         .psum  (bus.psum_in[i*PSUM_W +: PSUM_W]),
         .bin   (bin_s[i]),
         .clamp (clamp_s[i])
      );
   end

   assign bus.bias_ready = (state_q == S_IDLE);
   assign bus.psum_ready = (state_q == S_ACCUM);
   assign bus.out_valid  = (state_q == S_OUT);
   assign bus.busy       = (state_q != S_IDLE);
   assign bus.out_bins   = out_bins_q;
   assign bus.sat        = sat_q;

endmodule
